// File: rtl/wb_port_arbiter_pkg.sv
// Shared MIPS constants and the MDU result payload used by the writeback arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned NUM_REGS   = 1 << REG_IDX_W;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned STARVE_W   = 2;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic [DATA_W-1:0]    data;
    } mdu_result_t;

endpackage

// File: rtl/wb_port_arbiter_mdu_fifo.sv
// In-order MDU result buffer; ready and head depend only on registered state.
module mdu_result_fifo
    import wb_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  mdu_result_t push_data,
    input  logic        pop,
    output logic        ready_c,
    output logic        not_empty_c,
    output mdu_result_t head_c
);

    mdu_result_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   do_push;
    logic                   do_pop;

    assign ready_c     = (count < CNT_W'(FIFO_DEPTH));
    assign not_empty_c = (count != '0);
    assign head_c      = mem[rd_ptr];
    assign do_push     = push && ready_c;
    assign do_pop      = pop && not_empty_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered
// MDU results, with a busy scoreboard and a starvation guard for the MDU side.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 mdu_issue,
    input  logic [REG_IDX_W-1:0] mdu_issue_dest,
    input  logic                 mdu_valid,
    input  logic [REG_IDX_W-1:0] mdu_dest,
    input  logic [DATA_W-1:0]    mdu_data,
    output logic                 mdu_ready,
    input  logic [REG_IDX_W-1:0] rd_a,
    input  logic [REG_IDX_W-1:0] rd_b,
    input  logic [REG_IDX_W-1:0] hz_dest,
    output logic                 stall,
    output logic                 rf_wen,
    output logic [REG_IDX_W-1:0] rf_dest,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [NUM_REGS-1:0]  busy_mask,
    output logic                 starve
);

    mdu_result_t            head;
    mdu_result_t            push_data;
    logic                   fifo_ready;
    logic                   fifo_nempty;
    logic                   retire;
    logic [REG_IDX_W-1:0]   sel_dest;
    logic [DATA_W-1:0]      sel_data;
    logic [NUM_REGS-1:0]    busy_next;
    logic [STARVE_W-1:0]    starve_cnt;
    logic [STARVE_W-1:0]    starve_cnt_next;
    logic                   starve_next;

    assign push_data = '{dest: mdu_dest, data: mdu_data};
    assign mdu_ready = fifo_ready;

    mdu_result_fifo u_fifo (
        .clk         (CLK),
        .rst         (RST),
        .push        (mdu_valid),
        .push_data   (push_data),
        .pop         (retire),
        .ready_c     (fifo_ready),
        .not_empty_c (fifo_nempty),
        .head_c      (head)
    );

    // Writeback always wins the port; the FIFO head retires only when it is idle.
    always_comb begin
        sel_dest = '0;
        sel_data = '0;
        retire   = 1'b0;
        if (wb_en) begin
            sel_dest = wb_dest;
            sel_data = wb_data;
        end else if (fifo_nempty) begin
            sel_dest = head.dest;
            sel_data = head.data;
            retire   = 1'b1;
        end
    end

    assign rf_wen   = (wb_en || fifo_nempty) && (sel_dest != '0);
    assign rf_dest  = sel_dest;
    assign rf_wdata = sel_data;

    assign stall = busy_mask[rd_a] | busy_mask[rd_b] | busy_mask[hz_dest] | starve;

    // Issue is applied after retire so a same-register collision leaves the bit set.
    always_comb begin
        busy_next = busy_mask;
        if (retire) busy_next[head.dest] = 1'b0;
        if (mdu_issue && !stall && (mdu_issue_dest != '0)) busy_next[mdu_issue_dest] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        starve_cnt_next = starve_cnt;
        starve_next     = starve;
        if (retire || !fifo_nempty) begin
            starve_cnt_next = '0;
        end else if (wb_en && (starve_cnt != '1)) begin
            starve_cnt_next = starve_cnt + STARVE_W'(1);
        end
        if (retire) begin
            starve_next = 1'b0;
        end else if (starve_cnt_next == '1) begin
            starve_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_mask  <= '0;
            starve_cnt <= '0;
            starve     <= 1'b0;
        end else begin
            busy_mask  <= busy_next;
            starve_cnt <= starve_cnt_next;
            starve     <= starve_next;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench with a reference model and an expected-result queue for MDU writebacks.
module tb_wb_port_arbiter;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_data = '0;
    logic        mdu_issue = 1'b0;
    logic [4:0]  mdu_issue_dest = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_dest = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready;
    logic [4:0]  rd_a = '0;
    logic [4:0]  rd_b = '0;
    logic [4:0]  hz_dest = '0;
    logic        stall;
    logic        rf_wen;
    logic [4:0]  rf_dest;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;
    logic        starve;

    exp_t        mq[$];
    logic [31:0] mbusy = '0;
    logic [1:0]  mcnt = '0;
    logic        mstarve = 1'b0;
    int          errors = 0;
    int          checks = 0;

    wb_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .mdu_issue(mdu_issue), .mdu_issue_dest(mdu_issue_dest),
        .mdu_valid(mdu_valid), .mdu_dest(mdu_dest), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .rd_a(rd_a), .rd_b(rd_b), .hz_dest(hz_dest), .stall(stall),
        .rf_wen(rf_wen), .rf_dest(rf_dest), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .starve(starve)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare DUT against the model for the current inputs, then advance one clock.
    task automatic cyc();
        exp_t        h;
        int          n;
        logic        ret;
        logic        ewen;
        logic        stall_e;
        logic        push;
        logic [4:0]  edest;
        logic [31:0] edata;
        #1;
        n   = mq.size();
        ret = !wb_en && (n > 0);
        if (wb_en) begin
            edest = wb_dest;
            edata = wb_data;
        end else if (n > 0) begin
            edest = mq[0].dest;
            edata = mq[0].data;
        end else begin
            edest = '0;
            edata = '0;
        end
        ewen    = (wb_en || (n > 0)) && (edest != 0);
        stall_e = mbusy[rd_a] | mbusy[rd_b] | mbusy[hz_dest] | mstarve;
        chk("mdu_ready", 32'(mdu_ready), 32'(n < 2));
        chk("rf_wen", 32'(rf_wen), 32'(ewen));
        if (ewen) begin
            chk("rf_dest", 32'(rf_dest), 32'(edest));
            chk("rf_wdata", rf_wdata, edata);
        end
        chk("stall", 32'(stall), 32'(stall_e));
        chk("busy_mask", busy_mask, mbusy);
        chk("starve", 32'(starve), 32'(mstarve));
        push = mdu_valid && (n < 2);
        if (ret) begin
            h = mq.pop_front();
            mbusy[h.dest] = 1'b0;
        end
        if (mdu_issue && !stall_e && (mdu_issue_dest != 0)) mbusy[mdu_issue_dest] = 1'b1;
        mbusy[0] = 1'b0;
        if (ret || (n == 0)) mcnt = '0;
        else if (mcnt != 2'd3) mcnt = mcnt + 2'd1;
        if (ret) mstarve = 1'b0;
        else if (mcnt == 2'd3) mstarve = 1'b1;
        if (push) mq.push_back('{mdu_dest, mdu_data});
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        mbusy   = '0;
        mcnt    = '0;
        mstarve = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ready", 32'(mdu_ready), 32'd1);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_starve", 32'(starve), 32'd0);
        chk("rst_wen", 32'(rf_wen), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Single MDU result retires the cycle after its push
        mdu_issue = 1'b1; mdu_issue_dest = 5'd5; cyc();
        mdu_issue = 1'b0;
        chk("busy5_set", 32'(busy_mask[5]), 32'd1);
        mdu_valid = 1'b1; mdu_dest = 5'd5; mdu_data = 32'hAAAA;
        #1;
        chk("no_bypass", 32'(rf_wen), 32'd0);
        cyc();
        mdu_valid = 1'b0;
        #1;
        chk("retire5_data", rf_wdata, 32'hAAAA);
        cyc();
        chk("busy5_clear", 32'(busy_mask[5]), 32'd0);

        // RAW/WAW stall on a pending destination
        mdu_issue = 1'b1; mdu_issue_dest = 5'd7; cyc();
        mdu_issue = 1'b0; rd_a = 5'd7;
        cyc();
        rd_a = 5'd0; hz_dest = 5'd7;
        cyc();
        chk("stall_waw", 32'(stall), 32'd1);
        hz_dest = 5'd0; rd_a = 5'd7;
        mdu_valid = 1'b1; mdu_dest = 5'd7; mdu_data = 32'hBBBB; cyc();
        mdu_valid = 1'b0;
        chk("stall_retire_cycle", 32'(stall), 32'd1);
        cyc();
        chk("stall_released", 32'(stall), 32'd0);
        rd_a = 5'd0;

        // Full FIFO, writeback pressure, starvation hold
        mdu_issue = 1'b1; mdu_issue_dest = 5'd3; cyc();
        mdu_issue_dest = 5'd4; cyc();
        mdu_issue = 1'b0;
        wb_en = 1'b1; wb_dest = 5'd9; wb_data = 32'h1111;
        mdu_valid = 1'b1; mdu_dest = 5'd3; mdu_data = 32'h3333; cyc();
        mdu_dest = 5'd4; mdu_data = 32'h4444; wb_data = 32'h2222; cyc();
        mdu_dest = 5'd5; mdu_data = 32'hCCCC; wb_dest = 5'd10; wb_data = 32'h5555;
        #1;
        chk("full_not_ready", 32'(mdu_ready), 32'd0);
        cyc();
        mdu_valid = 1'b0;
        chk("starve_before", 32'(starve), 32'd0);
        cyc();
        chk("starve_after3", 32'(starve), 32'd1);
        chk("starve_stall", 32'(stall), 32'd1);
        wb_en = 1'b0; mdu_issue = 1'b1; mdu_issue_dest = 5'd12; cyc();
        mdu_issue = 1'b0;
        chk("starve_cleared", 32'(starve), 32'd0);
        chk("issue_ignored", 32'(busy_mask[12]), 32'd0);
        cyc();
        cyc();

        // Writeback to r0 still owns the port; issue to r0 never marks busy
        mdu_issue = 1'b1; mdu_issue_dest = 5'd6; cyc();
        mdu_issue_dest = 5'd0;
        mdu_valid = 1'b1; mdu_dest = 5'd6; mdu_data = 32'hDDDD;
        wb_en = 1'b1; wb_dest = 5'd0; wb_data = 32'h1234;
        cyc();
        mdu_issue = 1'b0; mdu_valid = 1'b0;
        chk("issue_r0_mask", busy_mask, 32'h0000_0040);
        #1;
        chk("wb_r0_wen", 32'(rf_wen), 32'd0);
        cyc();
        chk("wb_r0_no_pop", 32'(busy_mask[6]), 32'd1);
        wb_en = 1'b0;
        cyc();

        // Push and retire together at count 1
        mdu_valid = 1'b1; mdu_dest = 5'd13; mdu_data = 32'h1313; cyc();
        mdu_dest = 5'd14; mdu_data = 32'h1414; cyc();
        mdu_valid = 1'b0;
        #1;
        chk("new_head_dest", 32'(rf_dest), 32'd14);
        cyc();
        cyc();

        // Asynchronous reset mid-operation with a full FIFO
        mdu_issue = 1'b1; mdu_issue_dest = 5'd10; cyc();
        mdu_issue_dest = 5'd11; cyc();
        mdu_issue = 1'b0;
        wb_en = 1'b1; wb_dest = 5'd2; wb_data = 32'h7777;
        mdu_valid = 1'b1; mdu_dest = 5'd10; mdu_data = 32'hA0A0; cyc();
        mdu_dest = 5'd11; mdu_data = 32'hB0B0; cyc();
        mdu_valid = 1'b0; wb_en = 1'b0;
        chk("pre_rst_busy", busy_mask, 32'h0000_0C00);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_ready", 32'(mdu_ready), 32'd1);
        chk("arst_busy", busy_mask, 32'd0);
        chk("arst_starve", 32'(starve), 32'd0);
        chk("arst_wen", 32'(rf_wen), 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
